// File: rtl/top_fft.sv
// Streaming radix-2 DIF single-path-delay-feedback FFT with bit-reversed output order.
// Define FFT_SCALE_EN to halve every butterfly result (output = DFT/NFFT).
module top_fft #(
    parameter int INTEGER_SIZE = 16,
    parameter int FRACT_SIZE   = 16,
    parameter int NFFT         = 128
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start_FFT,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] serial_in_r,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] serial_in_i,
    output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] serial_out_r,
    output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] serial_out_i,
    output logic                                      end_FFT,
    output logic                                      data_valid_FFT
);
    localparam int DATA_WIDTH = INTEGER_SIZE + FRACT_SIZE;
    localparam int STAGES     = $clog2(NFFT);
    localparam int TW_AW      = STAGES - 1;
    localparam int E_LAST     = NFFT - 1 + STAGES;
    localparam int CNT_W      = $clog2(E_LAST + NFFT) + 1;
    localparam longint PI_Q28 = 64'sd843314857;
`ifdef FFT_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    // Elaboration-time cos/sin of 2*pi*k/NFFT via Q28 Taylor series, rounded to Q(FRACT_SIZE).
    function automatic logic signed [DATA_WIDTH-1:0] twiddle_q(input int k, input bit want_sin);
        longint x, x2, term, acc;
        int     pw;
        x    = (64'sd2 * PI_Q28 * longint'(k)) / longint'(NFFT);
        x2   = (x * x) >>> 28;
        term = want_sin ? x : (64'sd1 <<< 28);
        acc  = term;
        for (int n = 0; n < 16; n++) begin
            pw   = want_sin ? 2 * n + 1 : 2 * n;
            term = -(((term * x2) >>> 28) / longint'((pw + 1) * (pw + 2)));
            acc  = acc + term;
        end
        return DATA_WIDTH'((acc + (64'sd1 <<< (27 - FRACT_SIZE))) >>> (28 - FRACT_SIZE));
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] mul_trunc(input logic signed [2*DATA_WIDTH-1:0] p);
        return p[FRACT_SIZE+DATA_WIDTH-1:FRACT_SIZE];
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] bf_scale(input logic signed [DATA_WIDTH:0] v);
        return SCALE ? v[DATA_WIDTH:1] : v[DATA_WIDTH-1:0];
    endfunction

    logic signed [DATA_WIDTH-1:0] tw_r [NFFT/2];
    logic signed [DATA_WIDTH-1:0] tw_i [NFFT/2];

    for (genvar k = 0; k < NFFT / 2; k++) begin : g_rom
        localparam logic signed [DATA_WIDTH-1:0] TW_R = twiddle_q(k, 1'b0);
        localparam logic signed [DATA_WIDTH-1:0] TW_I = -twiddle_q(k, 1'b1);
        assign tw_r[k] = TW_R;
        assign tw_i[k] = TW_I;
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             capture, out_win, first_bin;
    logic             vld_out_p, end_out_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            vld_out_p <= 1'b0;
            end_out_p <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            vld_out_p <= out_win;
            end_out_p <= first_bin;
        end
    end

    // cnt equals the number of the upcoming edge, counted from the x[0] edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_nxt = start_FFT ? CNT_W'(1) : '0;
                if (start_FFT) state_nxt = LOAD;
            end
            LOAD:    if (cnt == CNT_W'(NFFT - 1)) state_nxt = FLUSH;
            FLUSH:   if (cnt == CNT_W'(E_LAST + NFFT - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture   = (state == LOAD) || (state == IDLE && start_FFT);
        out_win   = (state != IDLE) && (cnt >= CNT_W'(E_LAST)) && (cnt < CNT_W'(E_LAST + NFFT));
        first_bin = (state != IDLE) && (cnt == CNT_W'(E_LAST));
    end

    logic signed [DATA_WIDTH-1:0] chain_r [STAGES+1];
    logic signed [DATA_WIDTH-1:0] chain_i [STAGES+1];
    logic signed [DATA_WIDTH-1:0] in_r_p0, in_i_p0;

    // Input capture register
    always_ff @(posedge clk) begin
        in_r_p0 <= capture ? serial_in_r : '0;
        in_i_p0 <= capture ? serial_in_i : '0;
    end

    assign chain_r[0] = in_r_p0;
    assign chain_i[0] = in_i_p0;

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        localparam int D   = NFFT >> s;
        localparam int LD  = STAGES - s;
        localparam int OFF = NFFT - (NFFT >> (s - 1)) + s;

        logic signed [DATA_WIDTH-1:0] dl_r [D];
        logic signed [DATA_WIDTH-1:0] dl_i [D];
        logic signed [DATA_WIDTH-1:0] out_r_p, out_i_p;
        logic signed [DATA_WIDTH-1:0] sum_r, sum_i, dif_r, dif_i, fb_r, fb_i;
        logic [LD:0]                  k;
        logic                         bfly;

        // k is this stage's input sample index within the frame.
        assign k     = (LD + 1)'(cnt - CNT_W'(OFF));
        assign bfly  = k[LD];
        assign sum_r = bf_scale((DATA_WIDTH+1)'(dl_r[D-1]) + (DATA_WIDTH+1)'(chain_r[s-1]));
        assign sum_i = bf_scale((DATA_WIDTH+1)'(dl_i[D-1]) + (DATA_WIDTH+1)'(chain_i[s-1]));
        assign dif_r = bf_scale((DATA_WIDTH+1)'(dl_r[D-1]) - (DATA_WIDTH+1)'(chain_r[s-1]));
        assign dif_i = bf_scale((DATA_WIDTH+1)'(dl_i[D-1]) - (DATA_WIDTH+1)'(chain_i[s-1]));

        if (LD > 0) begin : g_tw
            logic [TW_AW-1:0]               addr;
            logic signed [2*DATA_WIDTH-1:0] pr, pi;
            assign addr = TW_AW'(k[LD-1:0]) << (s - 1);
            assign pr = (2*DATA_WIDTH)'(dif_r) * (2*DATA_WIDTH)'(tw_r[addr])
                      - (2*DATA_WIDTH)'(dif_i) * (2*DATA_WIDTH)'(tw_i[addr]);
            assign pi = (2*DATA_WIDTH)'(dif_r) * (2*DATA_WIDTH)'(tw_i[addr])
                      + (2*DATA_WIDTH)'(dif_i) * (2*DATA_WIDTH)'(tw_r[addr]);
            assign fb_r = mul_trunc(pr);
            assign fb_i = mul_trunc(pi);
        end else begin : g_unity
            assign fb_r = dif_r;
            assign fb_i = dif_i;
        end

        // Stage output register and feedback delay line
        always_ff @(posedge clk) begin
            out_r_p <= bfly ? sum_r : dl_r[D-1];
            out_i_p <= bfly ? sum_i : dl_i[D-1];
            dl_r[0] <= bfly ? fb_r : chain_r[s-1];
            dl_i[0] <= bfly ? fb_i : chain_i[s-1];
            for (int i = 1; i < D; i++) begin
                dl_r[i] <= dl_r[i-1];
                dl_i[i] <= dl_i[i-1];
            end
        end

        assign chain_r[s] = out_r_p;
        assign chain_i[s] = out_i_p;
    end

    assign serial_out_r   = vld_out_p ? chain_r[STAGES] : '0;
    assign serial_out_i   = vld_out_p ? chain_i[STAGES] : '0;
    assign data_valid_FFT = vld_out_p;
    assign end_FFT        = end_out_p;
endmodule

// File: tb/tb_top_fft.sv
// Bench for top_fft: reference DFT model in reals, bit-reversed output order, frame timing model.
// Honours FFT_SCALE_EN by expecting DFT/NFFT.
`timescale 1ns/1ps
module tb_top_fft;
    localparam int NFFT = 128;
    localparam int DW   = 32;
    localparam int LAT  = 134;
`ifdef FFT_SCALE_EN
    localparam real SC      = 128.0;
    localparam int  L_IMP   = 512;
    localparam int  L_DC    = 65536;
    localparam int  L_COS   = 32768;
    localparam int  TOL_GEN = 32;
`else
    localparam real SC      = 1.0;
    localparam int  L_IMP   = 65536;
    localparam int  L_DC    = 8388608;
    localparam int  L_COS   = 4194304;
    localparam int  TOL_GEN = 256;
`endif

    logic                 clk_tb = 1'b0;
    logic                 rst, start_FFT;
    logic signed [DW-1:0] serial_in_r, serial_in_i, serial_out_r, serial_out_i;
    logic                 end_FFT, data_valid_FFT;

    always #5 clk_tb = ~clk_tb;

    top_fft #(.INTEGER_SIZE(16), .FRACT_SIZE(16), .NFFT(NFFT)) dut (
        .clk(clk_tb), .rst(rst), .start_FFT(start_FFT),
        .serial_in_r(serial_in_r), .serial_in_i(serial_in_i),
        .serial_out_r(serial_out_r), .serial_out_i(serial_out_i),
        .end_FFT(end_FFT), .data_valid_FFT(data_valid_FFT)
    );

    int  n_cmp = 0, n_bad = 0;
    int  edge_n = 0, frame_e0 = 0, n_seen = 0;
    bit  active = 1'b0;
    int  tol = 2;
    int  xr [NFFT], xi [NFFT];
    int  got_r [NFFT], got_i [NFFT];
    real exp_r [NFFT], exp_i [NFFT];

    function automatic int bitrev(input int m);
        int r = 0;
        for (int b = 0; b < 7; b++) r = r | (((m >> b) & 1) << (6 - b));
        return r;
    endfunction

    task automatic check_val(input string name, input int idx, input int act, input real req, input real tl);
        real d;
        n_cmp++;
        d = $itor(act) - req;
        if (d < -tl || d > tl) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d, required %0.1f +-%0.1f", name, idx, act, req, tl);
        end
    endtask

    task automatic check_bit(input string name, input int idx, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b, required %b", name, idx, act, req);
        end
    endtask

    // Reference: X[b] = sum x[n] e^{-j 2 pi b n / N}, emitted at output index m with b = bitrev(m).
    task automatic build_model();
        real ar, ai, ang;
        int  b;
        for (int m = 0; m < NFFT; m++) begin
            b  = bitrev(m);
            ar = 0.0;
            ai = 0.0;
            for (int n = 0; n < NFFT; n++) begin
                ang = 2.0 * 3.14159265358979 * $itor((b * n) % NFFT) / $itor(NFFT);
                ar  = ar + $itor(xr[n]) * $cos(ang) + $itor(xi[n]) * $sin(ang);
                ai  = ai + $itor(xi[n]) * $cos(ang) - $itor(xr[n]) * $sin(ang);
            end
            exp_r[m] = ar / SC;
            exp_i[m] = ai / SC;
        end
    endtask

    // Per-cycle compare, sampled 1ns after each rising edge.
    initial forever begin
        int  rel;
        bit  exp_v, exp_e;
        @(posedge clk_tb);
        #1;
        edge_n++;
        rel   = edge_n - frame_e0;
        exp_v = active && rel >= LAT && rel < LAT + NFFT;
        exp_e = active && rel == LAT;
        if (data_valid_FFT === 1'b1) n_seen++;
        check_bit("data_valid", edge_n, data_valid_FFT, exp_v);
        check_bit("end_FFT", edge_n, end_FFT, exp_e);
        if (exp_v) begin
            got_r[rel-LAT] = serial_out_r;
            got_i[rel-LAT] = serial_out_i;
            check_val("bin_r", rel - LAT, serial_out_r, exp_r[rel-LAT], $itor(tol));
            check_val("bin_i", rel - LAT, serial_out_i, exp_i[rel-LAT], $itor(tol));
        end else begin
            check_val("idle_r", edge_n, serial_out_r, 0.0, 0.0);
            check_val("idle_i", edge_n, serial_out_i, 0.0, 0.0);
        end
    end

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            start_FFT   = 1'b0;
            serial_in_r = $urandom;
            serial_in_i = $urandom;
            @(negedge clk_tb);
        end
    endtask

    task automatic send_frame(input int extra_start_at, input int abort_at);
        build_model();
        n_seen = 0;
        for (int n = 0; n < NFFT; n++) begin
            if (n == abort_at) begin
                rst       = 1'b1;
                active    = 1'b0;
                start_FFT = 1'b0;
                @(negedge clk_tb);
                rst = 1'b0;
                idle_cycles(300);
                check_val("aborted_valid_count", 0, n_seen, 0.0, 0.0);
                return;
            end
            if (n == 0) begin
                frame_e0 = edge_n + 1;
                active   = 1'b1;
            end
            start_FFT   = (n == 0) || (n == extra_start_at);
            serial_in_r = xr[n];
            serial_in_i = xi[n];
            @(negedge clk_tb);
        end
        idle_cycles(LAT + 2);
        check_val("valid_count", 0, n_seen, $itor(NFFT), 0.0);
    endtask

    task automatic fill_random(input int amp);
        for (int n = 0; n < NFFT; n++) begin
            xr[n] = int'($urandom_range(0, 2 * amp)) - amp;
            xi[n] = int'($urandom_range(0, 2 * amp)) - amp;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_FFT = 1'b0; serial_in_r = '0; serial_in_i = '0;
        repeat (3) @(negedge clk_tb);
        check_bit("rst_valid", 0, data_valid_FFT, 1'b0);
        check_bit("rst_end", 0, end_FFT, 1'b0);
        check_val("rst_out_r", 0, serial_out_r, 0.0, 0.0);
        start_FFT = 1'b1;
        @(negedge clk_tb);
        rst = 1'b0;
        idle_cycles(5);

        for (int n = 0; n < NFFT; n++) begin xr[n] = 0; xi[n] = 0; end
        xr[0] = 65536;
        tol = 2;
        send_frame(-1, -1);
        check_val("model_imp", 33, int'(exp_r[33]), $itor(L_IMP), 0.0);
        check_val("imp_r", 0, got_r[0], $itor(L_IMP), 2.0);
        check_val("imp_r", 77, got_r[77], $itor(L_IMP), 2.0);
        check_val("imp_i", 3, got_i[3], 0.0, 2.0);

        for (int n = 0; n < NFFT; n++) begin xr[n] = 65536; xi[n] = 0; end
        tol = 4;
        send_frame(-1, -1);
        check_val("model_dc", 0, int'(exp_r[0]), $itor(L_DC), 0.5);
        check_val("dc_r", 0, got_r[0], $itor(L_DC), 4.0);
        check_val("dc_r", 1, got_r[1], 0.0, 4.0);

        for (int n = 0; n < NFFT; n++) begin
            xr[n] = int'(65536.0 * $cos(2.0 * 3.14159265358979 * $itor(n) / $itor(NFFT)));
            xi[n] = 0;
        end
        tol = TOL_GEN;
        send_frame(-1, -1);
        check_val("model_cos", 64, int'(exp_r[64]), $itor(L_COS), 2.0);
        check_val("cos_r", 64, got_r[64], $itor(L_COS), $itor(TOL_GEN));
        check_val("cos_r", 127, got_r[127], $itor(L_COS), $itor(TOL_GEN));
        check_val("cos_r", 1, got_r[1], 0.0, $itor(TOL_GEN));

        fill_random(16384);
        send_frame(20, -1);

        fill_random(16384);
        send_frame(-1, 40);

        fill_random(16384);
        send_frame(-1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
